// File: rtl/hdc_stream_pkg.sv
// Shared definitions for the HDC register-file streaming blocks.
package hdc_stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } stream_state_e;

  // Clamp a requested word count to the size of the register file.
  function automatic int unsigned sat_count(input int unsigned req, input int unsigned limit);
    return (req > limit) ? limit : req;
  endfunction

endpackage

// File: rtl/reg_file_rd_streamer.sv
// Walks a contiguous, wrapping range of register-file addresses and emits
// each word on a valid/ready stream, flagging the final word with last_o.
module reg_file_rd_streamer
  import hdc_stream_pkg::*;
#(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned NumRegs      = 32,
  parameter int unsigned NumRegsWidth = $clog2(NumRegs),
  parameter int unsigned CountWidth   = $clog2(NumRegs) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [NumRegsWidth-1:0] base_addr_i,
  input  logic [CountWidth-1:0]   num_words_i,
  input  logic                    abort_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [NumRegsWidth-1:0] rf_rd_addr_o,
  input  logic [DataWidth-1:0]    rf_rd_data_i,
  output logic [DataWidth-1:0]    data_o,
  output logic                    valid_o,
  output logic                    last_o,
  input  logic                    ready_i
);

  stream_state_e           state_q, state_d;
  logic [NumRegsWidth-1:0] addr_q, addr_d, addr_cur;
  logic [CountWidth-1:0]   words_left_q, words_left_d, words_left_cur;
  logic [CountWidth-1:0]   eff_count;
  logic [DataWidth-1:0]    data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    done_q, done_d;
  logic                    start_acc;
  logic                    abort_run;
  logic                    handshake;
  logic                    load;

  // Read address follows the command base while idle so the start cycle can
  // capture the first word directly.
  assign rf_rd_addr_o = (state_q == IDLE) ? base_addr_i : addr_q;

  assign busy_o  = (state_q == RUN);
  assign done_o  = done_q;
  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;

  // Next-state, address/count sequencing and output register stage.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    words_left_d = words_left_q;
    data_d       = data_q;
    valid_d      = valid_q;
    last_d       = last_q;
    done_d       = 1'b0;

    start_acc = (state_q == IDLE) && start_i;
    abort_run = (state_q == RUN) && abort_i;
    handshake = valid_q && ready_i;
    eff_count = CountWidth'(sat_count(32'(num_words_i), 32'(NumRegs)));

    // In the start cycle the command fields stand in for the registers.
    if (start_acc) begin
      words_left_cur = eff_count;
      addr_cur       = base_addr_i;
    end else begin
      words_left_cur = words_left_q;
      addr_cur       = addr_q;
    end

    load = (start_acc || (state_q == RUN)) && !abort_run &&
           (!valid_q || ready_i) && (words_left_cur != '0);

    if (abort_run) begin
      state_d      = IDLE;
      valid_d      = 1'b0;
      last_d       = 1'b0;
      words_left_d = '0;
    end else begin
      if (load) begin
        data_d       = rf_rd_data_i;
        valid_d      = 1'b1;
        last_d       = (words_left_cur == CountWidth'(1));
        addr_d       = addr_cur + NumRegsWidth'(1);
        words_left_d = words_left_cur - CountWidth'(1);
      end else if (handshake) begin
        valid_d = 1'b0;
        last_d  = 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (start_acc) begin
            if (eff_count == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (handshake && last_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      words_left_q <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      words_left_q <= words_left_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_reg_file_rd_streamer.sv
// Directed bench for reg_file_rd_streamer with a behavioural register file.
module tb_reg_file_rd_streamer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  base_addr;
  logic [5:0]  num_words;
  logic        abort;
  logic        busy;
  logic        done;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic [31:0] data;
  logic        valid;
  logic        last;
  logic        ready;

  logic [31:0] regs [32];

  int unsigned vectors;
  int unsigned miscompares;

  reg_file_rd_streamer #(
    .DataWidth (32),
    .NumRegs   (32)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .num_words_i  (num_words),
    .abort_i      (abort),
    .busy_o       (busy),
    .done_o       (done),
    .rf_rd_addr_o (rf_rd_addr),
    .rf_rd_data_i (rf_rd_data),
    .data_o       (data),
    .valid_o      (valid),
    .last_o       (last),
    .ready_i      (ready)
  );

  assign rf_rd_data = regs[rf_rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check one beat of the stream.
  task automatic beat(input string tag, input logic [31:0] exp_data, input logic exp_last);
    chk({tag, "_valid"}, {31'd0, valid}, 32'd1);
    chk({tag, "_data"}, data, exp_data);
    chk({tag, "_last"}, {31'd0, last}, {31'd0, exp_last});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
  endtask

  // Check the cycle after completion.
  task automatic finished(input string tag, input logic exp_done);
    chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic cmd(input logic [4:0] b, input logic [5:0] n);
    start     = 1'b1;
    base_addr = b;
    num_words = n;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 32; i++) regs[i] = 32'hA0 + 32'(i);
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = 5'd0;
    num_words = 6'd0;
    abort     = 1'b0;
    ready     = 1'b1;

    // Reset values
    #12;
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_last", {31'd0, last}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    base_addr = 5'd9;
    #1;
    chk("idle_addr", {27'd0, rf_rd_addr}, 32'd9);
    base_addr = 5'd0;
    rst_n = 1'b1;
    step();

    // Basic stream, base 0, 4 words
    cmd(5'd0, 6'd4);
    step(); start = 1'b0;
    beat("b0", 32'hA0, 1'b0);
    step(); beat("b1", 32'hA1, 1'b0);
    step(); beat("b2", 32'hA2, 1'b0);
    step(); beat("b3", 32'hA3, 1'b1);
    step(); finished("b_end", 1'b1);
    step(); chk("b_done_pulse", {31'd0, done}, 32'd0);

    // Backpressure; overwrite of an already-loaded word is not reflected
    cmd(5'd0, 6'd4);
    step(); start = 1'b0;
    beat("p0a", 32'hA0, 1'b0);
    ready = 1'b0; regs[0] = 32'hDEAD;
    step(); beat("p0b", 32'hA0, 1'b0);
    step(); beat("p0c", 32'hA0, 1'b0);
    ready = 1'b1;
    step(); beat("p1a", 32'hA1, 1'b0);
    ready = 1'b0;
    step(); beat("p1b", 32'hA1, 1'b0);
    ready = 1'b1;
    step(); beat("p2", 32'hA2, 1'b0);
    step(); beat("p3a", 32'hA3, 1'b1);
    ready = 1'b0;
    step(); beat("p3b", 32'hA3, 1'b1);
    chk("p3b_done", {31'd0, done}, 32'd0);
    ready = 1'b1;
    step(); finished("p_end", 1'b1);
    regs[0] = 32'hA0;
    step();

    // Address wrap: 30, 31, 0, 1
    cmd(5'd30, 6'd4);
    step(); start = 1'b0;
    beat("w0", 32'hBE, 1'b0);
    step(); beat("w1", 32'hBF, 1'b0);
    step(); beat("w2", 32'hA0, 1'b0);
    step(); beat("w3", 32'hA1, 1'b1);
    step(); finished("w_end", 1'b1);
    step();

    // Saturation: 40 requested -> exactly 32 words
    cmd(5'd3, 6'd40);
    step(); start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      beat("sat", 32'hA0 + 32'((i + 3) % 32), (i == 31));
      step();
    end
    finished("sat_end", 1'b1);
    step();

    // Zero count: no beat, done next cycle, then back-to-back start
    cmd(5'd4, 6'd0);
    step();
    finished("zero", 1'b1);
    cmd(5'd2, 6'd1);
    step(); start = 1'b0;
    beat("bb0", 32'hA2, 1'b1);
    step(); finished("bb0_end", 1'b1);
    cmd(5'd5, 6'd2);
    step(); start = 1'b0;
    beat("bb1a", 32'hA5, 1'b0);
    step(); beat("bb1b", 32'hA6, 1'b1);
    step(); finished("bb1_end", 1'b1);
    step();

    // Abort after two words while stalled
    cmd(5'd0, 6'd4);
    step(); start = 1'b0;
    beat("a0", 32'hA0, 1'b0);
    step(); beat("a1", 32'hA1, 1'b0);
    ready = 1'b0; abort = 1'b1;
    step(); abort = 1'b0; ready = 1'b1;
    finished("abort", 1'b0);
    chk("abort_last", {31'd0, last}, 32'd0);
    step(); finished("abort_after", 1'b0);

    // Abort wins over the handshake of the final beat
    cmd(5'd7, 6'd1);
    step(); start = 1'b0;
    beat("ap", 32'hA7, 1'b1);
    abort = 1'b1;
    step(); abort = 1'b0;
    finished("ap_end", 1'b0);
    step(); chk("ap_nodone", {31'd0, done}, 32'd0);

    // Abort in IDLE has no effect on an accepted start
    cmd(5'd3, 6'd1);
    abort = 1'b1;
    step(); start = 1'b0; abort = 1'b0;
    beat("ai", 32'hA3, 1'b1);
    step(); finished("ai_end", 1'b1);
    step();

    // start_i during RUN is ignored
    cmd(5'd0, 6'd3);
    step();
    beat("ig0", 32'hA0, 1'b0);
    cmd(5'd10, 6'd5);
    step(); start = 1'b0;
    beat("ig1", 32'hA1, 1'b0);
    step(); beat("ig2", 32'hA2, 1'b1);
    step(); finished("ig_end", 1'b1);
    step(); finished("ig_quiet", 1'b0);

    // Asynchronous reset mid-stream, then a fresh stream
    cmd(5'd0, 6'd4);
    step(); start = 1'b0;
    beat("r0", 32'hA0, 1'b0);
    step(); beat("r1", 32'hA1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("r_valid", {31'd0, valid}, 32'd0);
    chk("r_data", data, 32'd0);
    chk("r_last", {31'd0, last}, 32'd0);
    chk("r_busy", {31'd0, busy}, 32'd0);
    chk("r_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    step(); finished("r_idle", 1'b0);
    cmd(5'd0, 6'd2);
    step(); start = 1'b0;
    beat("rf0", 32'hA0, 1'b0);
    step(); beat("rf1", 32'hA1, 1'b1);
    step(); finished("rf_end", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
